layer_arbiter: RTL and testbench
================================

# layer_arbiter

Per-pixel arbiter that shares the 12-bit RGB output between the screen sources: main menu, game-over screen, dino, obstacle and ground. It sits between the sprite generators and the VGA pins, in the 25 MHz pixel-clock domain.
- Latches the game state once per frame, so a state change never tears mid-frame.
- Resolves layer priority through a 2-stage pipeline and delays the syncs to match.
- Detects dino/obstacle pixel overlap and raises `collided` for the game FSM.

## Interface
Parameters:
- H_SYNC, 96, Hsynq high while Hcount < H_SYNC
- V_SYNC, 2, Vsynq high while Vcount < V_SYNC
- H_VIS_START / H_VIS_END, 144 / 784, visible columns [start, end)
- V_VIS_START / V_VIS_END, 35 / 515, visible lines [start, end)
- COLL_FRAMES, 1, consecutive overlapping frames needed to assert collided (legal range 1..15)
- BG_RGB, 12'hFFF, background colour in visible area

Ports:
- clk  in  1  25 MHz pixel clock; one clock, all logic on rising edge
- resetButton  in  1  reset, synchronous, active-low
- Hcount, Vcount  in  16 each  raster position from the VGA counters
- gameState  in  3  000 menu, 001 run, 100 dead, others treated as idle
- menu_rgb, over_rgb  in  12 each  full-screen sources, {R,G,B}
- dino_vld, obst_vld, gnd_vld  in  1 each  source claims current pixel
- dino_rgb, obst_rgb, gnd_rgb  in  12 each  colour of claimed pixel
- Red, Green, Blue  out  4 each  registered pixel colour
- Hsynq, Vsynq  out  1 each  syncs delayed to align with RGB
- collided  out  1  level, overlap detected for COLL_FRAMES frames
- frame_start  out  1  one-cycle pulse when Hcount==0 && Vcount==0 is sampled

## Operation
- FSM states: IDLE, SYNCED.
  - Reset enters IDLE.
  - IDLE → SYNCED on the first Hcount==0 && Vcount==0. That first partial frame is never evaluated for collision.
  - There is no exit from SYNCED except reset.
- frame_state register: loaded from gameState at every frame start while SYNCED, and at the IDLE→SYNCED transition. It is held for the whole frame.
- In IDLE, RGB output is 0 for every pixel.
- Stage 1 selects the pixel colour:
  - Outside the visible window: 0.
  - frame_state 000: menu_rgb.
  - frame_state 100: over_rgb.
  - frame_state 001, highest priority first: obst_rgb if obst_vld, else dino_rgb if dino_vld, else gnd_rgb if gnd_vld, else BG_RGB.
  - Any other frame_state: BG_RGB.
- Stage 2 registers the result onto Red/Green/Blue. Hsynq/Vsynq pass through the same 2-deep delay.
- Collision:
  - Sticky bit `ovl` is set when dino_vld && obst_vld inside the visible window while frame_state==001.
  - At each frame start in SYNCED: if ovl, 4-bit counter cnt increments, saturating at COLL_FRAMES; otherwise cnt is cleared. ovl is then cleared.
  - collided = 1 once cnt == COLL_FRAMES.
  - collided is cleared, and cnt zeroed, when the newly latched frame_state ≠ 001.
- Simultaneous events: if an overlap pixel lands on Hcount==0 && Vcount==0, the pixel lies outside the visible window and is ignored. Evaluating the frame and clearing ovl take priority over setting ovl.

## Timing
- Reset values: Red/Green/Blue 0, Hsynq 0, Vsynq 0, collided 0, frame_start 0. Also ovl 0, cnt 0, frame_state 000, FSM IDLE.
- Pixel latency: inputs at cycle N appear on RGB/syncs at N+2. Syncs and RGB stay mutually aligned.
- frame_start is asserted at N+1 for a frame-start sample at N.
- collided updates at N+1 after the frame-start sample.
- Reset mid-frame: outputs zero on the next edge, and the block resynchronises at the next frame start.
- gameState changes mid-frame have no effect until the next frame start.

## Configuration
- COLLISION_HIGHLIGHT_EN defined: in frame_state 001, any pixel with dino_vld && obst_vld is output as 12'hF00. This overrides the normal priority.
- Macro undefined: the normal priority order applies. The highlight logic and its mux input are absent.
- Collision detection is identical in both builds.

## Structure
- Shared package `vga_game_pkg`:
  - Game-state codes ST_MENU=3'b000, ST_RUN=3'b001, ST_DEAD=3'b100.
  - Default VGA timing constants.
  - 12-bit rgb type.
- One sub-module, `coll_tracker`, holds the ovl/cnt/collided logic. All other logic stays in `layer_arbiter`.

## Test plan
- Reset mid-frame, release, run 2 frames of the raster → RGB 0 until the first frame start. frame_start pulses once per 800×525 clocks.
- frame_state 001, obst_vld=dino_vld=1 at (200,300), obst_rgb 12'h0F0, dino_rgb 12'h00F → output 12'h0F0 two cycles later. With COLLISION_HIGHLIGHT_EN: 12'hF00.
- gameState switches 000→100 at line 200 → menu_rgb held to end of frame; over_rgb from the next frame.
- COLL_FRAMES=3, overlap in frames 1, 2, 3 → collided rises one cycle after the frame-4 start. A gap in frame 2 delays the rise by the corresponding number of frames.
- collided=1, gameState→000 → collided falls one cycle after the next frame start.
- Hcount=50 → Hsynq=1 two cycles later; Hcount=96 → 0. Vsynq likewise for Vcount 1/2.

Source files
------------

// File: rtl/vga_game_pkg.sv
`default_nettype none
// ============================================================================
// vga_game_pkg : game-state codes, default VGA timing and pixel types
// Rev 1.0
// ============================================================================
package vga_game_pkg;

  typedef logic [11:0] rgb_t;

  localparam logic [2:0] ST_MENU = 3'b000;
  localparam logic [2:0] ST_RUN  = 3'b001;
  localparam logic [2:0] ST_DEAD = 3'b100;

  localparam int DEF_H_SYNC      = 96;
  localparam int DEF_V_SYNC      = 2;
  localparam int DEF_H_VIS_START = 144;
  localparam int DEF_H_VIS_END   = 784;
  localparam int DEF_V_VIS_START = 35;
  localparam int DEF_V_VIS_END   = 515;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    SYNCED = 1'b1
  } arb_state_e;

endpackage : vga_game_pkg
`default_nettype wire

// File: rtl/layer_arbiter_if.sv
`default_nettype none
// ============================================================================
// layer_arbiter_if : raster, sprite-source and VGA-pin bundle of layer_arbiter
// Rev 1.0
// ============================================================================
interface layer_arbiter_if;
  import vga_game_pkg::*;

  logic [15:0] Hcount;
  logic [15:0] Vcount;
  logic [2:0]  gameState;
  rgb_t        menu_rgb;
  rgb_t        over_rgb;
  logic        dino_vld;
  logic        obst_vld;
  logic        gnd_vld;
  rgb_t        dino_rgb;
  rgb_t        obst_rgb;
  rgb_t        gnd_rgb;
  logic [3:0]  Red;
  logic [3:0]  Green;
  logic [3:0]  Blue;
  logic        Hsynq;
  logic        Vsynq;
  logic        collided;
  logic        frame_start;

  // master: raster counters / sprite generators side
  modport master (
    output Hcount, Vcount, gameState, menu_rgb, over_rgb,
           dino_vld, obst_vld, gnd_vld, dino_rgb, obst_rgb, gnd_rgb,
    input  Red, Green, Blue, Hsynq, Vsynq, collided, frame_start
  );

  modport slave (
    input  Hcount, Vcount, gameState, menu_rgb, over_rgb,
           dino_vld, obst_vld, gnd_vld, dino_rgb, obst_rgb, gnd_rgb,
    output Red, Green, Blue, Hsynq, Vsynq, collided, frame_start
  );

endinterface : layer_arbiter_if
`default_nettype wire

// File: rtl/layer_arbiter_coll_tracker.sv
`default_nettype none
// ============================================================================
// coll_tracker : counts consecutive frames with dino/obstacle overlap
// Rev 1.0
// ============================================================================
module coll_tracker #(
  parameter int COLL_FRAMES = 1
) (
  input  wire logic clk,
  input  wire logic resetButton,
  input  wire logic frame_tick,
  input  wire logic run_next,
  input  wire logic pix_overlap,
  output logic      collided
);

  localparam logic [3:0] c_coll_frames = 4'(COLL_FRAMES);

  logic       r_ovl;
  logic [3:0] r_cnt;
  logic       r_collided;
  logic [3:0] w_cnt_next;

  // Leaving the run state always forgets any partial collision history
  always_comb begin
    w_cnt_next = '0;
    if (run_next && r_ovl) begin
      w_cnt_next = (r_cnt >= c_coll_frames) ? c_coll_frames : r_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetButton) begin
      r_ovl      <= 1'b0;
      r_cnt      <= '0;
      r_collided <= 1'b0;
    end else if (frame_tick) begin
      r_cnt      <= w_cnt_next;
      r_collided <= run_next && (w_cnt_next == c_coll_frames);
      r_ovl      <= 1'b0;
    end else if (pix_overlap) begin
      r_ovl <= 1'b1;
    end
  end

  assign collided = r_collided;

endmodule : coll_tracker
`default_nettype wire

// File: rtl/layer_arbiter.sv
`default_nettype none
// ============================================================================
// layer_arbiter : per-pixel RGB layer priority, 2-stage pipe, collision flag
// Optional macro COLLISION_HIGHLIGHT_EN paints overlap pixels red. Rev 1.0
// ============================================================================
module layer_arbiter
  import vga_game_pkg::*;
#(
  parameter int   H_SYNC      = DEF_H_SYNC,
  parameter int   V_SYNC      = DEF_V_SYNC,
  parameter int   H_VIS_START = DEF_H_VIS_START,
  parameter int   H_VIS_END   = DEF_H_VIS_END,
  parameter int   V_VIS_START = DEF_V_VIS_START,
  parameter int   V_VIS_END   = DEF_V_VIS_END,
  parameter int   COLL_FRAMES = 1,
  parameter rgb_t BG_RGB      = 12'hFFF
) (
  input wire logic       clk,
  input wire logic       resetButton,
  layer_arbiter_if.slave bus
);

  localparam logic [15:0] c_h_sync      = 16'(H_SYNC);
  localparam logic [15:0] c_v_sync      = 16'(V_SYNC);
  localparam logic [15:0] c_h_vis_start = 16'(H_VIS_START);
  localparam logic [15:0] c_h_vis_end   = 16'(H_VIS_END);
  localparam logic [15:0] c_v_vis_start = 16'(V_VIS_START);
  localparam logic [15:0] c_v_vis_end   = 16'(V_VIS_END);
`ifdef COLLISION_HIGHLIGHT_EN
  localparam rgb_t        c_highlight   = 12'hF00;
`endif

  arb_state_e r_state;
  logic [2:0] r_frame_state;
  logic       r_frame_start;
  rgb_t       r_s1_rgb;
  logic       r_s1_hs;
  logic       r_s1_vs;
  rgb_t       r_rgb;
  logic       r_hs;
  logic       r_vs;

  logic w_frame_start;
  logic w_visible;
  logic w_overlap;
  logic w_run_pix;
  logic w_collided;
  rgb_t w_pix;

  assign w_frame_start = (bus.Hcount == 16'd0) && (bus.Vcount == 16'd0);
  assign w_visible     = (bus.Hcount >= c_h_vis_start) && (bus.Hcount < c_h_vis_end) &&
                         (bus.Vcount >= c_v_vis_start) && (bus.Vcount < c_v_vis_end);
  assign w_overlap     = bus.dino_vld && bus.obst_vld;
  assign w_run_pix     = (r_state == SYNCED) && w_visible && (r_frame_state == ST_RUN);

  always_comb begin
    w_pix = '0;
    if ((r_state == SYNCED) && w_visible) begin
      case (r_frame_state)
        ST_MENU: w_pix = bus.menu_rgb;
        ST_DEAD: w_pix = bus.over_rgb;
        ST_RUN: begin
          if (bus.obst_vld)      w_pix = bus.obst_rgb;
          else if (bus.dino_vld) w_pix = bus.dino_rgb;
          else if (bus.gnd_vld)  w_pix = bus.gnd_rgb;
          else                   w_pix = BG_RGB;
`ifdef COLLISION_HIGHLIGHT_EN
          if (w_overlap) w_pix = c_highlight;
`endif
        end
        default: w_pix = BG_RGB;
      endcase
    end
  end

  // Frame state is only sampled on the (0,0) pixel so a frame never tears
  always_ff @(posedge clk) begin
    if (!resetButton) begin
      r_state       <= IDLE;
      r_frame_state <= ST_MENU;
      r_frame_start <= 1'b0;
      r_s1_rgb      <= '0;
      r_s1_hs       <= 1'b0;
      r_s1_vs       <= 1'b0;
      r_rgb         <= '0;
      r_hs          <= 1'b0;
      r_vs          <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_frame_start) begin
            r_state       <= SYNCED;
            r_frame_state <= bus.gameState;
          end
        end
        SYNCED: begin
          if (w_frame_start) r_frame_state <= bus.gameState;
        end
      endcase
      r_frame_start <= w_frame_start;
      r_s1_rgb      <= w_pix;
      r_s1_hs       <= (bus.Hcount < c_h_sync);
      r_s1_vs       <= (bus.Vcount < c_v_sync);
      r_rgb         <= r_s1_rgb;
      r_hs          <= r_s1_hs;
      r_vs          <= r_s1_vs;
    end
  end

  coll_tracker #(
    .COLL_FRAMES (COLL_FRAMES)
  ) u_coll_tracker (
    .clk         (clk),
    .resetButton (resetButton),
    .frame_tick  ((r_state == SYNCED) && w_frame_start),
    .run_next    (bus.gameState == ST_RUN),
    .pix_overlap (w_run_pix && w_overlap),
    .collided    (w_collided)
  );

  assign bus.Red         = r_rgb[11:8];
  assign bus.Green       = r_rgb[7:4];
  assign bus.Blue        = r_rgb[3:0];
  assign bus.Hsynq       = r_hs;
  assign bus.Vsynq       = r_vs;
  assign bus.frame_start = r_frame_start;
  assign bus.collided    = w_collided;

endmodule : layer_arbiter
`default_nettype wire

// File: tb/tb_layer_arbiter.sv
`default_nettype none
// ============================================================================
// tb_layer_arbiter : directed vectors with a queued scoreboard for layer_arbiter
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_layer_arbiter;
  import vga_game_pkg::*;

  localparam int COLL = 3;
`ifdef COLLISION_HIGHLIGHT_EN
  localparam logic [11:0] HL = 12'hF00;
`else
  localparam logic [11:0] HL = 12'h0F0;
`endif

  logic clk = 1'b0;
  logic resetButton;
  always #20 clk = ~clk;

  layer_arbiter_if bus();

  layer_arbiter #(.COLL_FRAMES(COLL)) dut (
    .clk         (clk),
    .resetButton (resetButton),
    .bus         (bus)
  );

  typedef struct {
    int          due;
    int          kind;   // 0 pixel+syncs, 1 frame_start, 2 collided
    int          tag;
    logic [11:0] rgb;
    logic        hs;
    logic        vs;
    logic        bit_v;
  } exp_t;

  exp_t q[$];
  int   cyc     = 0;
  int   tag     = 0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void cmp(input string name, input int t, input int got, input int exp_v);
    n_tests++;
    if (got != exp_v) begin
      n_fail++;
      $display("FAIL %s vec%0d: got %0h expected %0h", name, t, got, exp_v);
    end
  endfunction

  // Monitor: compares every queued expectation that falls due this cycle
  always @(negedge clk) begin
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].due < cyc) begin
        cmp("late_expectation", q[i].tag, 1, 0);
        q.delete(i);
      end else if (q[i].due == cyc) begin
        case (q[i].kind)
          0: begin
            cmp("rgb", q[i].tag, int'({bus.Red, bus.Green, bus.Blue}), int'(q[i].rgb));
            cmp("hsynq", q[i].tag, int'(bus.Hsynq), int'(q[i].hs));
            cmp("vsynq", q[i].tag, int'(bus.Vsynq), int'(q[i].vs));
          end
          1: cmp("frame_start", q[i].tag, int'(bus.frame_start), int'(q[i].bit_v));
          default: cmp("collided", q[i].tag, int'(bus.collided), int'(q[i].bit_v));
        endcase
        q.delete(i);
      end
    end
  end

  task automatic push(input int due, input int kind, input logic [11:0] rgb,
                      input logic hs, input logic vs, input logic b);
    exp_t e;
    e.due = due; e.kind = kind; e.tag = tag;
    e.rgb = rgb; e.hs = hs; e.vs = vs; e.bit_v = b;
    q.push_back(e);
  endtask

  // Drive one pixel; RGB/syncs due two edges later, frame_start one edge later
  task automatic px(input int h, input int v, input logic [2:0] gs,
                    input logic d, input logic o, input logic g, input logic [11:0] exp_rgb);
    bus.Hcount    = 16'(h);
    bus.Vcount    = 16'(v);
    bus.gameState = gs;
    bus.dino_vld  = d;
    bus.obst_vld  = o;
    bus.gnd_vld   = g;
    push(cyc + 2, 0, exp_rgb, (h < 96), (v < 2), 1'b0);
    push(cyc + 1, 1, 12'h0, 1'b0, 1'b0, (h == 0) && (v == 0));
    tag++;
    @(posedge clk); #1;
  endtask

  // Expected collided value right after the next pixel is sampled
  task automatic chk_coll(input logic exp_c);
    push(cyc + 1, 2, 12'h0, 1'b0, 1'b0, exp_c);
  endtask

  task automatic run_frame(input logic overlap, input logic exp_c);
    chk_coll(exp_c);
    px(0, 0, ST_RUN, 1'b0, 1'b0, 1'b0, 12'h000);
    if (overlap) px(300, 100, ST_RUN, 1'b1, 1'b1, 1'b0, HL);
    else         px(300, 100, ST_RUN, 1'b1, 1'b0, 1'b0, 12'h00F);
    px(400, 100, ST_RUN, 1'b0, 1'b0, 1'b0, 12'hFFF);
  endtask

  task automatic do_reset();
    resetButton = 1'b0;
    q.delete();
    @(posedge clk); #1;
    cmp("reset_rgb", tag, int'({bus.Red, bus.Green, bus.Blue}), 0);
    cmp("reset_hsynq", tag, int'(bus.Hsynq), 0);
    cmp("reset_vsynq", tag, int'(bus.Vsynq), 0);
    cmp("reset_collided", tag, int'(bus.collided), 0);
    cmp("reset_frame_start", tag, int'(bus.frame_start), 0);
    resetButton = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.Hcount = '0; bus.Vcount = 16'd1; bus.gameState = ST_RUN;
    bus.menu_rgb = 12'h123; bus.over_rgb = 12'h456;
    bus.dino_rgb = 12'h00F; bus.obst_rgb = 12'h0F0; bus.gnd_rgb = 12'h0AA;
    bus.dino_vld = 1'b0; bus.obst_vld = 1'b0; bus.gnd_vld = 1'b0;
    resetButton = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // IDLE: syncs flow, colour stays black, overlap ignored
    px(200, 300, ST_RUN, 1, 1, 1, 12'h000);
    px(50, 1, ST_RUN, 0, 0, 0, 12'h000);
    px(96, 2, ST_RUN, 0, 0, 0, 12'h000);
    px(95, 1, ST_RUN, 0, 0, 0, 12'h000);

    // Frame 1 (run): priority and window edges; overlap at (200,300)
    chk_coll(1'b0);
    px(0, 0, ST_RUN, 0, 0, 0, 12'h000);
    px(200, 300, ST_RUN, 1, 1, 1, HL);
    px(201, 300, ST_RUN, 1, 0, 1, 12'h00F);
    px(202, 300, ST_RUN, 0, 0, 1, 12'h0AA);
    px(203, 300, ST_RUN, 0, 0, 0, 12'hFFF);
    px(143, 300, ST_RUN, 0, 1, 0, 12'h000);
    px(144, 35, ST_RUN, 0, 1, 0, 12'h0F0);
    px(783, 514, ST_RUN, 0, 0, 1, 12'h0AA);
    px(784, 514, ST_RUN, 0, 0, 1, 12'h000);
    px(144, 515, ST_RUN, 0, 0, 1, 12'h000);
    px(144, 34, ST_RUN, 0, 0, 1, 12'h000);

    // Frames 2,3 with overlap; collided rises after the frame-4 start
    run_frame(1'b1, 1'b0);
    run_frame(1'b1, 1'b0);
    chk_coll(1'b0);
    px(500, 200, ST_RUN, 0, 0, 0, 12'hFFF);
    run_frame(1'b1, 1'b1);
    chk_coll(1'b1);
    px(500, 200, ST_RUN, 0, 0, 0, 12'hFFF);

    // Frame 5 menu: collided falls, gameState change mid-frame ignored
    chk_coll(1'b0);
    px(0, 0, ST_MENU, 0, 0, 0, 12'h000);
    px(200, 150, ST_MENU, 1, 1, 1, 12'h123);
    px(200, 200, ST_DEAD, 1, 1, 1, 12'h123);
    px(300, 400, ST_DEAD, 0, 0, 0, 12'h123);

    // Frame 6 game over, frame 7 unknown state -> background
    px(0, 0, ST_DEAD, 0, 0, 0, 12'h000);
    px(200, 300, ST_DEAD, 0, 0, 0, 12'h456);
    px(100, 300, ST_DEAD, 0, 0, 0, 12'h000);
    px(200, 300, 3'b010, 0, 0, 0, 12'h456);
    px(0, 0, 3'b010, 0, 0, 0, 12'h000);
    px(200, 300, 3'b010, 1, 1, 1, 12'hFFF);
    px(200, 300, ST_RUN, 1, 1, 1, 12'hFFF);

    // Gap in the overlap run delays the rise; count saturates then clears
    run_frame(1'b1, 1'b0);
    run_frame(1'b0, 1'b0);
    run_frame(1'b1, 1'b0);
    run_frame(1'b1, 1'b0);
    run_frame(1'b1, 1'b0);
    run_frame(1'b1, 1'b1);
    run_frame(1'b0, 1'b1);
    run_frame(1'b1, 1'b0);
    run_frame(1'b1, 1'b0);
    run_frame(1'b1, 1'b0);
    run_frame(1'b1, 1'b1);

    // Mid-frame reset, then resynchronise on the next frame start
    px(50, 1, ST_RUN, 1, 1, 1, 12'h000);
    px(200, 300, ST_RUN, 1, 1, 1, HL);
    do_reset();
    px(200, 300, ST_RUN, 1, 1, 1, 12'h000);
    px(50, 1, ST_RUN, 0, 0, 0, 12'h000);
    chk_coll(1'b0);
    px(0, 0, ST_RUN, 0, 0, 0, 12'h000);
    px(200, 300, ST_RUN, 1, 1, 1, HL);
    run_frame(1'b0, 1'b0);

    for (int i = 0; i < 10 && q.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    if (q.size() != 0) cmp("queue_drain", tag, q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_layer_arbiter
`default_nettype wire
